// File: rtl/merge_pick_pkg.sv
// Shared types and constants for the two-pick merge initiator.
package merge_pick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  localparam int unsigned DEF_N    = 10;
  localparam int unsigned DEF_IDXW = 4;
  localparam int unsigned DEF_VALW = 4;
  localparam int unsigned EMPTY_VAL = 0;

endpackage

// File: rtl/merge_pick_debounce.sv
// One button: 2-FF synchroniser, stability counter, one-cycle pulse on accepted rise.
module merge_pick_debounce #(
  parameter int unsigned DB_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DB_CYC + 1);

  logic          s1_q, s2_q;
  logic          acc_q, acc_d;
  logic          pulse_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees with the
  // accepted one; any agreeing sample restarts the stability window.
  always_comb begin
    acc_d = acc_q;
    cnt_d = '0;
    if (s2_q != acc_q) begin
      if (cnt_q == CW'(DB_CYC - 1)) acc_d = s2_q;
      else                          cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pulse_q <= acc_d & ~acc_q;
    end
  end

  assign press_o = pulse_q;

endmodule

// File: rtl/merge_pick_issuer.sv
// Debounced first/second pick selection issuing one (A, B) pair per merge over valid/ready.
module merge_pick_issuer
  import merge_pick_pkg::*;
#(
  parameter int unsigned N       = DEF_N,
  parameter int unsigned IDXW    = DEF_IDXW,
  parameter int unsigned VALW    = DEF_VALW,
  parameter int unsigned DB_CYC  = 16,
  parameter int unsigned TMO_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N-1:0]      buttons,
  input  logic [N*VALW-1:0] status,
  output logic              pick_valid,
  output logic [IDXW-1:0]   pick_a,
  output logic [IDXW-1:0]   pick_b,
  input  logic              pick_ready,
  output logic              sel_pending,
  output logic [IDXW-1:0]   sel_index,
  output logic              err_pulse
);

  localparam int unsigned TW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

  logic [N-1:0] press;

  for (genvar g = 0; g < N; g++) begin : g_db
    merge_pick_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (buttons[g]),
      .press_o (press[g])
    );
  end

  // Lowest pressed index wins; losers in the same cycle are simply dropped.
  logic            hit;
  logic [IDXW-1:0] hit_idx;
  logic [VALW-1:0] hit_val;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_val = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (press[i]) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
        hit_val = status[i*VALW +: VALW];
      end
    end
  end

  logic hit_full;
  assign hit_full = (hit_val != VALW'(EMPTY_VAL));

  state_e          state_q, state_d;
  logic [IDXW-1:0] a_q, a_d, b_q, b_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            err_q, err_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tmr_d   = tmr_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && hit) begin
          if (hit_full) begin
            state_d = ST_HOLD;
            a_d     = hit_idx;
            tmr_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        tmr_d = tmr_q + TW'(1);
        // Timeout outranks a same-cycle press; disable outranks both silently.
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tmr_q == TW'(TMO_CYC - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (hit) begin
          if (hit_idx == a_q) begin
            state_d = ST_IDLE;
          end else if (hit_full) begin
            state_d = ST_ISSUE;
            b_d     = hit_idx;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (pick_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
    end
  end

  assign pick_valid  = (state_q == ST_ISSUE);
  assign pick_a      = a_q;
  assign pick_b      = b_q;
  assign sel_pending = (state_q == ST_HOLD);
  assign sel_index   = (state_q == ST_HOLD) ? a_q : '0;
  assign err_pulse   = err_q;

endmodule

// File: tb/tb_merge_pick_issuer.sv
// Directed bench for merge_pick_issuer: debounce, pairing, back-pressure, errors, timeout, reset.
module tb_merge_pick_issuer;

  localparam int N = 10, IDXW = 4, VALW = 4, DB = 16, TMO = 100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [N-1:0]      buttons;
  logic [N*VALW-1:0] status;
  logic              pick_valid;
  logic [IDXW-1:0]   pick_a, pick_b, sel_index;
  logic              pick_ready;
  logic              sel_pending;
  logic              err_pulse;

  int checks = 0;
  int errs   = 0;

  merge_pick_issuer #(.N(N), .IDXW(IDXW), .VALW(VALW), .DB_CYC(DB), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .buttons(buttons), .status(status),
    .pick_valid(pick_valid), .pick_a(pick_a), .pick_b(pick_b), .pick_ready(pick_ready),
    .sel_pending(sel_pending), .sel_index(sel_index), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise a button and land on the cycle where the FSM reacts (2 sync + DB + 1).
  task automatic push(input int i);
    buttons[i] = 1'b1;
    step(DB + 3);
  endtask

  task automatic release_btn(input int i);
    buttons[i] = 1'b0;
    step(DB + 3);
  endtask

  initial begin
    logic bad;
    rst_n = 1'b0; enable = 1'b1; buttons = '0; pick_ready = 1'b1;
    for (int i = 0; i < N; i++) status[i*VALW +: VALW] = (i == 4) ? 4'd0 : 4'd1;
    step(3);
    chk("rst_valid", pick_valid, 0);
    chk("rst_a", pick_a, 0);
    chk("rst_b", pick_b, 0);
    chk("rst_pend", sel_pending, 0);
    chk("rst_sidx", sel_index, 0);
    chk("rst_err", err_pulse, 0);
    rst_n = 1'b1;
    step(2);

    // Bounce on button 3: 10 toggles, 4 cycles apart, then high for good.
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      buttons[3] = ~buttons[3];
      for (int c = 0; c < 4; c++) begin
        step(1);
        if (sel_pending || err_pulse) bad = 1'b1;
      end
    end
    chk("bounce_quiet", bad, 0);
    buttons[3] = 1'b1;
    step(DB + 2);
    chk("bounce_early", sel_pending, 0);
    step(1);
    chk("bounce_hold", sel_pending, 1);
    chk("bounce_idx", sel_index, 3);
    release_btn(3);
    push(3);
    chk("cancel3_idle", sel_pending, 0);
    chk("cancel3_noerr", err_pulse, 0);
    release_btn(3);

    // Normal pair 2 -> 5 with ready high.
    push(2);
    chk("pair_pend", sel_pending, 1);
    chk("pair_sidx", sel_index, 2);
    chk("pair_novalid", pick_valid, 0);
    release_btn(2);
    push(5);
    chk("pair_valid", pick_valid, 1);
    chk("pair_a", pick_a, 2);
    chk("pair_b", pick_b, 5);
    chk("pair_pend_off", sel_pending, 0);
    step(1);
    chk("pair_done", pick_valid, 0);
    release_btn(5);

    // Back-pressure: ready low while button 7 is pressed during ISSUE.
    pick_ready = 1'b0;
    push(2);
    release_btn(2);
    push(5);
    chk("bp_valid", pick_valid, 1);
    buttons[5] = 1'b0;
    buttons[7] = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 25; c++) begin
      step(1);
      if (!pick_valid || pick_a != 4'd2 || pick_b != 4'd5 || sel_pending) bad = 1'b1;
    end
    chk("bp_stable", bad, 0);
    pick_ready = 1'b1;
    step(1);
    chk("bp_release", pick_valid, 0);
    step(1);
    chk("bp_ignored7", sel_pending, 0);
    release_btn(7);

    // Empty pick and cancel on button 1.
    push(4);
    chk("empty_err", err_pulse, 1);
    chk("empty_idle", sel_pending, 0);
    step(1);
    chk("empty_err1cyc", err_pulse, 0);
    release_btn(4);
    push(1);
    chk("c1_hold", sel_pending, 1);
    chk("c1_sidx", sel_index, 1);
    release_btn(1);
    push(1);
    chk("c1_cancel", sel_pending, 0);
    chk("c1_noerr", err_pulse, 0);
    chk("c1_sidx0", sel_index, 0);
    release_btn(1);

    // Empty second pick keeps HOLD; enable low then drops it silently.
    push(2);
    release_btn(2);
    push(4);
    chk("hold_empty_err", err_pulse, 1);
    chk("hold_empty_stay", sel_pending, 1);
    enable = 1'b0;
    step(1);
    chk("dis_idle", sel_pending, 0);
    chk("dis_noerr", err_pulse, 0);
    enable = 1'b1;
    release_btn(4);

    // Timeout: HOLD entry at push return, exit exactly TMO cycles later.
    push(6);
    chk("tmo_hold", sel_pending, 1);
    release_btn(6);
    step(TMO - 1 - (DB + 3));
    chk("tmo_before", sel_pending, 1);
    chk("tmo_before_err", err_pulse, 0);
    step(1);
    chk("tmo_idle", sel_pending, 0);
    chk("tmo_err", err_pulse, 1);
    step(1);
    chk("tmo_err1cyc", err_pulse, 0);

    // Simultaneous 8 and 3: only 3 is taken.
    buttons[8] = 1'b1;
    buttons[3] = 1'b1;
    step(DB + 3);
    chk("sim_hold", sel_pending, 1);
    chk("sim_idx", sel_index, 3);
    buttons[8] = 1'b0;
    buttons[3] = 1'b0;
    step(DB + 3);
    chk("sim_still3", sel_index, 3);
    pick_ready = 1'b0;
    push(8);
    chk("sim_valid", pick_valid, 1);
    chk("sim_a", pick_a, 3);
    chk("sim_b", pick_b, 8);
    buttons[8] = 1'b0;
    step(2);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", pick_valid, 0);
    chk("arst_a", pick_a, 0);
    chk("arst_b", pick_b, 0);
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("post_rst_valid", pick_valid, 0);
    chk("post_rst_pend", sel_pending, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
